order_trigger: RTL and testbench

Downstream consumer of the market-data parser's price_data/price_valid pulse.
- Compares each qualifying price against buy/sell thresholds.
- On a trigger, serialises a fixed-format order message onto a byte-wide AXI-Stream with backpressure, bound for the TX MAC.
- A cooldown counter rate-limits orders; counters expose sent/dropped activity.

---
 rtl/order_trigger.sv | 215 +++++++++++++++++++++
 tb/tb_order_trigger.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_trigger.sv
// Threshold-triggered order generator: emits a fixed-format order message on a byte-wide
// AXI-Stream, then rate-limits itself with a cooldown. Define ORDER_CHECKSUM_EN for an XOR trailer byte.
module order_trigger #(
    parameter int COOLDOWN_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      price_data,
    input  logic             price_valid,
    input  logic [31:0]      order_symbol,
    input  logic [31:0]      buy_threshold,
    input  logic [31:0]      sell_threshold,
    input  logic             enable,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             busy,
    output logic [CNT_W-1:0] orders_sent,
    output logic [CNT_W-1:0] drop_count
);

`ifdef ORDER_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif

    localparam int CD_W = (COOLDOWN_CYCLES > 2) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

    localparam logic [7:0] SIDE_BUY  = 8'h42;
    localparam logic [7:0] SIDE_SELL = 8'h53;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

`ifdef ORDER_CHECKSUM_EN
    // XOR of the nine header/payload bytes plus the sequence byte.
    function automatic logic [7:0] msg_xor(
        input logic [7:0]  side,
        input logic [31:0] sym,
        input logic [31:0] price,
        input logic [7:0]  seq
    );
        msg_xor = side ^ sym[31:24] ^ sym[23:16] ^ sym[15:8] ^ sym[7:0]
                ^ price[31:24] ^ price[23:16] ^ price[15:8] ^ price[7:0] ^ seq;
    endfunction
`endif

    // Byte at position idx of the order message, MSB-first fields.
    function automatic logic [7:0] msg_byte(
        input logic [3:0]  idx,
        input logic [7:0]  side,
        input logic [31:0] sym,
        input logic [31:0] price,
        input logic [7:0]  seq
    );
        case (idx)
            4'd0:    msg_byte = side;
            4'd1:    msg_byte = sym[31:24];
            4'd2:    msg_byte = sym[23:16];
            4'd3:    msg_byte = sym[15:8];
            4'd4:    msg_byte = sym[7:0];
            4'd5:    msg_byte = price[31:24];
            4'd6:    msg_byte = price[23:16];
            4'd7:    msg_byte = price[15:8];
            4'd8:    msg_byte = price[7:0];
            4'd9:    msg_byte = seq;
`ifdef ORDER_CHECKSUM_EN
            4'd10:   msg_byte = msg_xor(side, sym, price, seq);
`endif
            default: msg_byte = 8'h00;
        endcase
    endfunction

    state_t            state_r;
    logic [3:0]        idx_r;
    logic [7:0]        side_r;
    logic [31:0]       sym_r;
    logic [31:0]       price_r;
    logic [7:0]        seq_r;
    logic [CD_W-1:0]   cd_r;
    logic [7:0]        tdata_r;
    logic              tvalid_r;
    logic              tlast_r;
    logic              busy_r;
    logic [CNT_W-1:0]  sent_r;
    logic [CNT_W-1:0]  drop_r;

    logic              buy_hit_s;
    logic              sell_hit_s;
    logic              trig_s;
    logic [7:0]        side_s;
    logic              hs_s;
    logic [3:0]        next_idx_s;
    logic [7:0]        next_byte_s;

    // Trigger qualification and next-byte selection.
    always_comb begin
        buy_hit_s   = (price_data < buy_threshold);
        sell_hit_s  = (price_data > sell_threshold);
        trig_s      = price_valid & enable & (buy_hit_s | sell_hit_s);
        if (buy_hit_s) begin
            side_s = SIDE_BUY;
        end else begin
            side_s = SIDE_SELL;
        end
        hs_s        = tvalid_r & m_axis_tready;
        next_idx_s  = idx_r + 4'd1;
        next_byte_s = msg_byte(next_idx_s, side_r, sym_r, price_r, seq_r);
    end

    // Main FSM: capture, serialise, cooldown, and activity counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            idx_r    <= 4'd0;
            side_r   <= 8'h00;
            sym_r    <= 32'h0000_0000;
            price_r  <= 32'h0000_0000;
            seq_r    <= 8'h00;
            cd_r     <= '0;
            tdata_r  <= 8'h00;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b0;
            sent_r   <= '0;
            drop_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (trig_s) begin
                        side_r   <= side_s;
                        sym_r    <= order_symbol;
                        price_r  <= price_data;
                        idx_r    <= 4'd0;
                        tdata_r  <= side_s;
                        tvalid_r <= 1'b1;
                        tlast_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= SEND;
                    end else begin
                        tvalid_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                SEND: begin
                    if (trig_s && (drop_r != {CNT_W{1'b1}})) begin
                        drop_r <= drop_r + 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                    if (hs_s) begin
                        if (idx_r == LAST_IDX) begin
                            tvalid_r <= 1'b0;
                            tlast_r  <= 1'b0;
                            tdata_r  <= 8'h00;
                            seq_r    <= seq_r + 8'd1;
                            if (sent_r != {CNT_W{1'b1}}) begin
                                sent_r <= sent_r + 1'b1;
                            end else begin
                                sent_r <= sent_r;
                            end
                            if (COOLDOWN_CYCLES > 0) begin
                                cd_r    <= CD_LOAD;
                                state_r <= COOLDOWN;
                            end else begin
                                busy_r  <= 1'b0;
                                state_r <= IDLE;
                            end
                        end else begin
                            idx_r   <= next_idx_s;
                            tdata_r <= next_byte_s;
                            tlast_r <= (next_idx_s == LAST_IDX);
                        end
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                COOLDOWN: begin
                    if (trig_s && (drop_r != {CNT_W{1'b1}})) begin
                        drop_r <= drop_r + 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                    if (cd_r == '0) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cd_r <= cd_r - 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign busy          = busy_r;
    assign orders_sent   = sent_r;
    assign drop_count    = drop_r;

endmodule

// File: tb/tb_order_trigger.sv
// Self-checking bench for order_trigger: scoreboard of expected stream bytes plus per-scenario checks.
module tb_order_trigger;

`ifdef ORDER_CHECKSUM_EN
    localparam int PKT_LEN = 11;
`else
    localparam int PKT_LEN = 10;
`endif
    localparam int CD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] price_data = 32'h0;
    logic        price_valid = 1'b0;
    logic [31:0] order_symbol = 32'h0;
    logic [31:0] buy_threshold = 32'h0;
    logic [31:0] sell_threshold = 32'hFFFF_FFFF;
    logic        enable = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] orders_sent;
    logic [15:0] drop_count;

    order_trigger #(.COOLDOWN_CYCLES(CD), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .price_data     (price_data),
        .price_valid    (price_valid),
        .order_symbol   (order_symbol),
        .buy_threshold  (buy_threshold),
        .sell_threshold (sell_threshold),
        .enable         (enable),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
        .orders_sent    (orders_sent),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         hs_count = 0;
    int         stall_count = 0;
    logic [8:0] exp_q[$];
    logic [7:0] exp_seq = 8'h00;
    bit         bp_mode = 1'b0;
    bit         held_pending = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_last = 1'b0;

    // tready driver: toggles every cycle in backpressure mode, otherwise held high.
    always @(posedge clk) begin
        #1;
        if (bp_mode) m_axis_tready = ~m_axis_tready;
        else         m_axis_tready = 1'b1;
    end

    // Scoreboard monitor: pops an expected {tlast,tdata} per handshake and checks stall stability.
    always @(negedge clk) begin
        logic [8:0] e;
        if (held_pending) begin
            n_checks++;
            if (!m_axis_tvalid || m_axis_tdata !== held_data || m_axis_tlast !== held_last) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, required v=1 d=%02h l=%0b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_data, held_last);
            end
        end
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            hs_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %02h last=%0b, none required", m_axis_tdata, m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                if ({m_axis_tlast, m_axis_tdata} !== e) begin
                    n_fail++;
                    $display("FAIL stream_byte: got last=%0b d=%02h, required last=%0b d=%02h",
                             m_axis_tlast, m_axis_tdata, e[8], e[7:0]);
                end
            end
        end
        if (rst_n && m_axis_tvalid && !m_axis_tready) stall_count++;
        held_pending = rst_n && m_axis_tvalid && !m_axis_tready;
        held_data    = m_axis_tdata;
        held_last    = m_axis_tlast;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] p);
        price_data  = p;
        price_valid = 1'b1;
        step(1);
        price_valid = 1'b0;
    endtask

    // Reference message built independently from the field values.
    task automatic push_pkt(input logic [7:0] side, input logic [31:0] sym, input logic [31:0] price);
        logic [7:0] b[11];
        logic [7:0] x;
        b[0] = side;
        b[1] = sym[31:24];   b[2] = sym[23:16];   b[3] = sym[15:8];   b[4] = sym[7:0];
        b[5] = price[31:24]; b[6] = price[23:16]; b[7] = price[15:8]; b[8] = price[7:0];
        b[9] = exp_seq;
        x = 8'h00;
        for (int i = 0; i < 10; i++) x = x ^ b[i];
        b[10] = x;
        for (int i = 0; i < PKT_LEN; i++) exp_q.push_back({(i == PKT_LEN - 1), b[i]});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_done(output bit timed_out);
        int c;
        c = 0;
        while ((busy || m_axis_tvalid) && c < 300) begin
            step(1);
            c++;
        end
        timed_out = (c >= 300);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b l=%0b d=%02h busy=%0b, required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy);
        end
        n_checks++;
        if (orders_sent !== 16'd0 || drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got sent=%0d drop=%0d, required 0 0", orders_sent, drop_count);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_buy;
        int bc;
        enable         = 1'b1;
        buy_threshold  = 32'h0000_1000;
        sell_threshold = 32'hFFFF_FFFF;
        order_symbol   = 32'h54534C41;
        push_pkt(8'h42, 32'h54534C41, 32'h0000_0FFF);
        pulse(32'h0000_0FFF);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h42) begin
            n_fail++;
            $display("FAIL buy_latency: got v=%0b d=%02h, required v=1 d=42", m_axis_tvalid, m_axis_tdata);
        end
        bc = 0;
        while (busy && bc < 300) begin
            bc++;
            step(1);
        end
        n_checks++;
        if (bc != PKT_LEN + CD) begin
            n_fail++;
            $display("FAIL buy_busy_len: got %0d cycles, required %0d", bc, PKT_LEN + CD);
        end
        n_checks++;
        if (orders_sent !== 16'd1 || exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL buy_done: got sent=%0d left=%0d v=%0b, required 1 0 0",
                     orders_sent, exp_q.size(), m_axis_tvalid);
        end
    endtask

    task automatic test_sell_backpressure;
        bit to;
        buy_threshold  = 32'h0;
        sell_threshold = 32'h0000_0100;
        hs_count    = 0;
        stall_count = 0;
        bp_mode     = 1'b1;
        push_pkt(8'h53, 32'h54534C41, 32'h0000_0200);
        pulse(32'h0000_0200);
        wait_done(to);
        bp_mode = 1'b0;
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL sell_timeout: got busy after 300 cycles, required idle");
        end
        n_checks++;
        if (hs_count != PKT_LEN || stall_count == 0) begin
            n_fail++;
            $display("FAIL sell_handshakes: got hs=%0d stalls=%0d, required hs=%0d stalls>0",
                     hs_count, stall_count, PKT_LEN);
        end
        n_checks++;
        if (orders_sent !== 16'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sell_done: got sent=%0d left=%0d, required 2 0", orders_sent, exp_q.size());
        end
    endtask

    task automatic test_no_trigger;
        buy_threshold  = 32'h0000_0500;
        sell_threshold = 32'h0000_0500;
        hs_count = 0;
        pulse(32'h0000_0500);
        step(2);
        enable = 1'b0;
        pulse(32'h0000_0010);
        step(2);
        enable = 1'b1;
        n_checks++;
        if (hs_count != 0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trigger: got hs=%0d busy=%0b v=%0b, required 0 0 0", hs_count, busy, m_axis_tvalid);
        end
        n_checks++;
        if (orders_sent !== 16'd2 || drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL no_trigger_cnt: got sent=%0d drop=%0d, required 2 0", orders_sent, drop_count);
        end
    endtask

    task automatic test_drop_busy;
        bit to;
        int c;
        buy_threshold  = 32'h0000_1000;
        sell_threshold = 32'hFFFF_FFFF;
        hs_count = 0;
        push_pkt(8'h42, 32'h54534C41, 32'h0000_0800);
        pulse(32'h0000_0800);
        step(3);
        pulse(32'h0000_0801);
        c = 0;
        while (m_axis_tvalid && c < 100) begin
            step(1);
            c++;
        end
        step(2);
        pulse(32'h0000_0900);
        wait_done(to);
        step(3);
        n_checks++;
        if (to || c >= 100) begin
            n_fail++;
            $display("FAIL drop_timeout: got no return to idle, required idle");
        end
        n_checks++;
        if (drop_count !== 16'd2 || hs_count != PKT_LEN) begin
            n_fail++;
            $display("FAIL drop_busy: got drop=%0d hs=%0d, required 2 %0d", drop_count, hs_count, PKT_LEN);
        end
        n_checks++;
        if (orders_sent !== 16'd3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drop_sent: got sent=%0d left=%0d, required 3 0", orders_sent, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        push_pkt(8'h42, 32'h54534C41, 32'h0000_0123);
        pulse(32'h0000_0123);
        wait_done(to);
        order_symbol = 32'h41415049;
        push_pkt(8'h42, 32'h41415049, 32'h0000_0456);
        pulse(32'h0000_0456);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || to) begin
            n_fail++;
            $display("FAIL reentry_trigger: got v=%0b, required 1", m_axis_tvalid);
        end
        order_symbol  = 32'hDEADBEEF;
        buy_threshold = 32'h0;
        wait_done(to);
        n_checks++;
        if (orders_sent !== 16'd5 || drop_count !== 16'd2 || exp_q.size() != 0 || to) begin
            n_fail++;
            $display("FAIL back_to_back: got sent=%0d drop=%0d left=%0d, required 5 2 0",
                     orders_sent, drop_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_packet;
        bit to;
        int c;
        buy_threshold = 32'h0000_1000;
        order_symbol  = 32'h54534C41;
        hs_count = 0;
        push_pkt(8'h42, 32'h54534C41, 32'h0000_0AAA);
        pulse(32'h0000_0AAA);
        c = 0;
        while (hs_count < 5 && c < 100) begin
            step(1);
            c++;
        end
        rst_n = 1'b0;
        step(1);
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 || c >= 100) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got v=%0b l=%0b busy=%0b, required 0 0 0",
                     m_axis_tvalid, m_axis_tlast, busy);
        end
        n_checks++;
        if (orders_sent !== 16'd0 || drop_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_counters: got sent=%0d drop=%0d, required 0 0", orders_sent, drop_count);
        end
        exp_q.delete();
        exp_seq = 8'h00;
        rst_n = 1'b1;
        step(1);
        hs_count = 0;
        push_pkt(8'h42, 32'h54534C41, 32'h0000_0FFF);
        pulse(32'h0000_0FFF);
        wait_done(to);
        n_checks++;
        if (to || orders_sent !== 16'd1 || hs_count != PKT_LEN || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: got sent=%0d hs=%0d left=%0d, required 1 %0d 0",
                     orders_sent, hs_count, exp_q.size(), PKT_LEN);
        end
    endtask

    initial begin
        test_reset();
        test_buy();
        test_sell_backpressure();
        test_no_trigger();
        test_drop_busy();
        test_back_to_back();
        test_reset_mid_packet();
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
